// File: rtl/multimode_counter_register_if.sv
`default_nettype none
// ============================================================================
// Module   : multimode_counter_register_if
// Function : Control, data and status bundle of the multi-mode register.
// Revision : 1.0
// ============================================================================
interface multimode_counter_register_if #(
  parameter int N = 4
);
  logic         En;
  logic [2:0]   M;
  logic [N-1:0] Din;
  logic         SinR;
  logic         SinL;
  logic [N-1:0] Q;
  logic         Sout;
  logic         TC;
  logic         Zero;

  modport master (
    output En, M, Din, SinR, SinL,
    input  Q, Sout, TC, Zero
  );

  modport slave (
    input  En, M, Din, SinR, SinL,
    output Q, Sout, TC, Zero
  );
endinterface
`default_nettype wire

// File: rtl/multimode_counter_register.sv
`default_nettype none
// ============================================================================
// Module   : multimode_counter_register
// Function : N-bit hold/shift/rotate/modulo-count/load register with serial
//            I/O, terminal-count pulse and zero flag. Build macro SATURATE_EN
//            makes counting saturate instead of wrap.
// Revision : 1.0
// ============================================================================
module multimode_counter_register #(
  parameter int N      = 4,
  parameter int MODMAX = (1 << N) - 1
) (
  input  wire logic ClockEn,
  input  wire logic RST,
  multimode_counter_register_if.slave bus
);

  localparam logic [2:0] c_hold  = 3'b000;
  localparam logic [2:0] c_shr   = 3'b001;
  localparam logic [2:0] c_shl   = 3'b010;
  localparam logic [2:0] c_rotr  = 3'b011;
  localparam logic [2:0] c_rotl  = 3'b100;
  localparam logic [2:0] c_inc   = 3'b101;
  localparam logic [2:0] c_dec   = 3'b110;
  localparam logic [2:0] c_load  = 3'b111;

  localparam logic [N-1:0] c_modmax = MODMAX[N-1:0];
  localparam logic [N-1:0] c_one    = {{(N-1){1'b0}}, 1'b1};

`ifdef SATURATE_EN
  localparam logic [N-1:0] c_up_limit = c_modmax;
  localparam logic [N-1:0] c_dn_limit = '0;
`else
  localparam logic [N-1:0] c_up_limit = '0;
  localparam logic [N-1:0] c_dn_limit = c_modmax;
`endif

  logic [N-1:0] q_q, q_d;
  logic         sout_q, sout_d;
  logic         tc_q, tc_d;

  always_ff @(posedge ClockEn or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      tc_q   <= tc_d;
    end
  end

  // TC defaults low so it can only ever be a single-edge pulse per wrap.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    tc_d   = 1'b0;
    if (bus.En) begin
      case (bus.M)
        c_hold: ;
        c_shr: begin
          q_d    = {bus.SinR, q_q[N-1:1]};
          sout_d = q_q[0];
        end
        c_shl: begin
          q_d    = {q_q[N-2:0], bus.SinL};
          sout_d = q_q[N-1];
        end
        c_rotr: begin
          q_d    = {q_q[0], q_q[N-1:1]};
          sout_d = q_q[0];
        end
        c_rotl: begin
          q_d    = {q_q[N-2:0], q_q[N-1]};
          sout_d = q_q[N-1];
        end
        c_inc: begin
          // ">=" also catches loaded values above the modulus.
          if (q_q >= c_modmax) begin
            q_d  = c_up_limit;
            tc_d = 1'b1;
          end else begin
            q_d  = q_q + c_one;
          end
        end
        c_dec: begin
          if (q_q == '0) begin
            q_d  = c_dn_limit;
            tc_d = 1'b1;
          end else begin
            q_d  = q_q - c_one;
          end
        end
        c_load: q_d = bus.Din;
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_q;
  assign bus.Sout = sout_q;
  assign bus.TC   = tc_q;
  assign bus.Zero = (q_q == '0);

endmodule
`default_nettype wire
